// File: rtl/mem_access_sequencer.sv
// Initiator-side sequencer for the unified instruction/data memory: screens
// fetch/load/store requests, waits out the BRAM read latency and captures the result.
module mem_access_sequencer #(
    parameter int INSTR_LIMIT  = 80,
    parameter int AW           = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [1:0]    resp_fault,
    output logic [31:0]   resp_data,
    output logic [31:0]   instr_reg,
    output logic [31:0]   data_reg,
    output logic [AW-1:0] mem_address,
    output logic [31:0]   mem_writeData,
    output logic          mem_MemWrite,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] OP_FETCH   = 2'b00;
    localparam logic [1:0] OP_STORE   = 2'b10;
    localparam logic [1:0] F_OK       = 2'b00;
    localparam logic [1:0] F_MISALIGN = 2'b01;
    localparam logic [1:0] F_PROT     = 2'b10;
    localparam logic [1:0] F_RANGE    = 2'b11;

    localparam int          RANGE_MAX_I = (1 << AW) - 4;
    localparam logic [AW:0] RANGE_MAX   = RANGE_MAX_I[AW:0];
    localparam logic [AW:0] LIMIT       = INSTR_LIMIT[AW:0];
    localparam logic [1:0]  LAT         = READ_LATENCY[1:0];

    // Misalignment outranks range, which outranks region protection.
    function automatic logic [1:0] fault_check(input logic [1:0] op, input logic [AW-1:0] addr);
        logic [AW:0] a;
        a = {1'b0, addr};
        if (addr[1:0] != 2'b00)
            return F_MISALIGN;
        else if (a > RANGE_MAX)
            return F_RANGE;
        else if ((op == OP_STORE && a < LIMIT) || (op == OP_FETCH && a >= LIMIT))
            return F_PROT;
        else
            return F_OK;
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_op;
    logic [31:0]   r_wdata;
    logic [1:0]    r_cnt;
    logic [1:0]    r_resp_fault;
    logic [31:0]   r_resp_data;
    logic [31:0]   r_instr;
    logic [31:0]   r_data;
    logic [AW-1:0] r_mem_address;
    logic [1:0]    w_fault;
    logic          w_accept;
    logic          w_write;

    assign w_fault  = fault_check(req_op, req_addr);
    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_write  = (r_state == S_ISSUE) && (r_op == OP_STORE);

    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = (r_state == S_RESP);
    assign resp_fault    = r_resp_fault;
    assign resp_data     = r_resp_data;
    assign instr_reg     = r_instr;
    assign data_reg      = r_data;
    assign mem_address   = r_mem_address;
    assign mem_MemWrite  = w_write;
    assign mem_writeData = w_write ? r_wdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = (w_fault != F_OK) ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = (r_op == OP_STORE) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 2'd1) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op          <= 2'b00;
            r_wdata       <= 32'd0;
            r_cnt         <= 2'd0;
            r_resp_fault  <= F_OK;
            r_resp_data   <= 32'd0;
            r_instr       <= 32'd0;
            r_data        <= 32'd0;
            r_mem_address <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op;
                        r_wdata <= req_wdata;
                        // A faulting request never reaches the memory address bus.
                        if (w_fault != F_OK)
                            r_resp_fault <= w_fault;
                        else
                            r_mem_address <= req_addr;
                    end
                end
                S_ISSUE: begin
                    if (r_op != OP_STORE)
                        r_cnt <= LAT;
                end
                S_WAIT: begin
                    if (r_cnt == 2'd1) begin
                        if (r_op == OP_FETCH) begin
                            r_instr     <= mem_rdata;
                            r_resp_data <= mem_rdata;
                        end else begin
                            r_data      <= byte_swap(mem_rdata);
                            r_resp_data <= byte_swap(mem_rdata);
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_fault <= F_OK;
                        r_resp_data  <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: vector table plus hand-written backpressure,
// long-latency and mid-operation reset sequences against a unified memory model.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Instance with READ_LATENCY=1
    logic        req_valid, req_ready, resp_valid, resp_ready, mem_MemWrite;
    logic [1:0]  req_op, resp_fault;
    logic [9:0]  req_addr, mem_address;
    logic [31:0] req_wdata, resp_data, instr_reg, data_reg, mem_writeData, mem_rdata;

    // Instance with READ_LATENCY=3
    logic        d3_req_valid, d3_req_ready, d3_resp_valid, d3_resp_ready, d3_mem_MemWrite;
    logic [1:0]  d3_req_op, d3_resp_fault;
    logic [9:0]  d3_req_addr, d3_mem_address;
    logic [31:0] d3_req_wdata, d3_resp_data, d3_instr_reg, d3_data_reg, d3_mem_writeData, d3_mem_rdata;

    mem_access_sequencer #(.INSTR_LIMIT(80), .AW(10), .READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_fault(resp_fault),
        .resp_data(resp_data), .instr_reg(instr_reg), .data_reg(data_reg),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_MemWrite(mem_MemWrite), .mem_rdata(mem_rdata)
    );

    mem_access_sequencer #(.INSTR_LIMIT(80), .AW(10), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_op(d3_req_op),
        .req_addr(d3_req_addr), .req_wdata(d3_req_wdata),
        .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready), .resp_fault(d3_resp_fault),
        .resp_data(d3_resp_data), .instr_reg(d3_instr_reg), .data_reg(d3_data_reg),
        .mem_address(d3_mem_address), .mem_writeData(d3_mem_writeData),
        .mem_MemWrite(d3_mem_MemWrite), .mem_rdata(d3_mem_rdata)
    );

    // Unified memory: bytes written little-endian, read back big-endian,
    // with a few preloaded instruction/data words.
    logic [7:0]  mem [0:1023];
    logic [31:0] p1;
    logic [31:0] p3 [0:2];

    function automatic logic [31:0] rd(input logic [9:0] a);
        if (a == 10'h004) return 32'h8C010050;
        if (a == 10'h04C) return 32'h00000013;
        if (a == 10'h3FC) return 32'hA1B2C3D4;
        return {mem[a], mem[a + 10'd1], mem[a + 10'd2], mem[a + 10'd3]};
    endfunction

    always @(posedge clk) begin
        if (mem_MemWrite)
            for (int i = 0; i < 4; i++)
                mem[mem_address + 10'(i)] <= mem_writeData[8*i +: 8];
        p1    <= rd(mem_address);
        p3[0] <= rd(d3_mem_address);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata    = p1;
    assign d3_mem_rdata = p3[2];

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  fault;
        logic [31:0] data;
        int          lat;
        int          nwr;
    } vec_t;

    typedef struct {
        logic [1:0]  fault;
        logic [31:0] data;
        int          lat;
    } exp_t;

    vec_t        vecs [12];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_instr = 32'd0;
    logic [31:0] exp_data  = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v);
        exp_t e;
        int   cyc;
        int   wr;
        bit   seen;
        @(negedge clk);
        check32("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        e.fault = v.fault; e.data = v.data; e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; wr = 0; seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1 && v.fault == 2'b00) check32("issue_addr", 32'(mem_address), 32'(v.addr));
            if (mem_MemWrite) wr++;
            if (resp_valid) begin seen = 1'b1; cyc = k; end
        end
        e = sb.pop_front();
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout: addr %h no response in 20 cycles", v.addr);
        end
        check32("latency", 32'(cyc), 32'(e.lat));
        check32("resp_fault", 32'(resp_fault), 32'(e.fault));
        check32("resp_data", resp_data, e.data);
        check32("memwrite_cycles", 32'(wr), 32'(v.nwr));
        if (v.fault == 2'b00 && v.op == 2'b00) exp_instr = v.data;
        if (v.fault == 2'b00 && v.op[0]) exp_data = v.data;
        check32("instr_reg", instr_reg, exp_instr);
        check32("data_reg", data_reg, exp_data);
        @(negedge clk);
        check32("resp_cleared", {31'd0, resp_valid} | resp_data | 32'(resp_fault), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int   cyc;
        bit   seen;
        logic [31:0] held;

        vecs[0]  = '{2'b00, 10'h004, 32'h0,        2'b00, 32'h8C010050, 3, 0};
        vecs[1]  = '{2'b10, 10'h054, 32'h11223344, 2'b00, 32'h0,        2, 1};
        vecs[2]  = '{2'b01, 10'h054, 32'h0,        2'b00, 32'h11223344, 3, 0};
        vecs[3]  = '{2'b10, 10'h028, 32'hDEADBEEF, 2'b10, 32'h0,        1, 0};
        vecs[4]  = '{2'b01, 10'h052, 32'h0,        2'b01, 32'h0,        1, 0};
        vecs[5]  = '{2'b00, 10'h050, 32'h0,        2'b10, 32'h0,        1, 0};
        vecs[6]  = '{2'b01, 10'h3FD, 32'h0,        2'b01, 32'h0,        1, 0};
        vecs[7]  = '{2'b01, 10'h3FC, 32'h0,        2'b00, 32'hD4C3B2A1, 3, 0};
        vecs[8]  = '{2'b11, 10'h054, 32'h0,        2'b00, 32'h11223344, 3, 0};
        vecs[9]  = '{2'b10, 10'h050, 32'hCAFEF00D, 2'b00, 32'h0,        2, 1};
        vecs[10] = '{2'b00, 10'h04C, 32'h0,        2'b00, 32'h00000013, 3, 0};
        vecs[11] = '{2'b00, 10'h001, 32'h0,        2'b01, 32'h0,        1, 0};

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        d3_req_valid = 1'b0; d3_req_op = 2'b00; d3_req_addr = '0; d3_req_wdata = '0; d3_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check32("rst_req_ready", 32'(req_ready), 32'd1);
        check32("rst_resp", {31'd0, resp_valid} | resp_data | 32'(resp_fault), 32'd0);
        check32("rst_regs", instr_reg | data_reg, 32'd0);
        check32("rst_mem", 32'(mem_address) | mem_writeData | {31'd0, mem_MemWrite}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_req(vecs[i]);

        // Backpressure: response held 5 cycles while the next request waits.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 10'h054; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_op = 2'b00; req_addr = 10'h004;
        seen = 1'b0; cyc = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1'b1; cyc = k; end
        end
        check32("bp_latency", 32'(cyc), 32'd3);
        held = resp_data;
        check32("bp_data", held, 32'h11223344);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check32("bp_hold_valid", 32'(resp_valid), 32'd1);
            check32("bp_hold_data", resp_data, held);
            check32("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check32("bp_after_ready", 32'(req_ready), 32'd1);
        check32("bp_after_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0; cyc = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1'b1; cyc = k; end
        end
        check32("bp_next_latency", 32'(cyc), 32'd3);
        check32("bp_next_data", resp_data, 32'h8C010050);
        check32("bp_next_instr", instr_reg, 32'h8C010050);
        @(negedge clk);

        // Three-cycle read latency: a fetch and a load of the stored word.
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check32("rl3_ready", 32'(d3_req_ready), 32'd1);
            d3_req_valid = 1'b1;
            d3_req_op    = (j == 0) ? 2'b00 : 2'b01;
            d3_req_addr  = (j == 0) ? 10'h004 : 10'h054;
            @(posedge clk);
            #1 d3_req_valid = 1'b0;
            seen = 1'b0; cyc = 0;
            for (int k = 1; k <= 20 && !seen; k++) begin
                @(negedge clk);
                if (d3_mem_MemWrite || d3_mem_writeData != 32'd0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rl3_memwrite: got %b expected 0", d3_mem_MemWrite);
                end
                if (d3_resp_valid) begin seen = 1'b1; cyc = k; end
            end
            check32("rl3_latency", 32'(cyc), 32'd5);
            check32("rl3_fault", 32'(d3_resp_fault), 32'd0);
            check32("rl3_data", d3_resp_data, (j == 0) ? 32'h8C010050 : 32'h11223344);
            check32("rl3_regs", (j == 0) ? d3_instr_reg : d3_data_reg, (j == 0) ? 32'h8C010050 : 32'h11223344);
            @(negedge clk);
        end

        // Reset asserted in the WAIT state of a load.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 10'h054;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check32("wait_no_resp", 32'(resp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check32("arst_req_ready", 32'(req_ready), 32'd1);
        check32("arst_resp", {31'd0, resp_valid} | resp_data | 32'(resp_fault), 32'd0);
        check32("arst_regs", instr_reg | data_reg, 32'd0);
        check32("arst_mem", 32'(mem_address) | mem_writeData | {31'd0, mem_MemWrite}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_instr = 32'd0;
        exp_data  = 32'd0;
        run_req(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Initiator side of the unified instruction/data memory in the MultiCycle core. It sits between the control FSM and the byte-addressed memory block.
- Accepts fetch/load/store requests over a valid/ready handshake and drives address, writeData and MemWrite. It waits out the synchronous BRAM read latency, then captures the returned word into an instruction register or a memory-data register.
- Rejects illegal accesses before they reach memory. Corrects the memory's byte order on data-region loads.

Parameters:
- INSTR_LIMIT, 80: first byte address of the data region; addresses below it are instruction space.
- AW, 10: byte-address width.
- READ_LATENCY, 1: clock cycles from the address being sampled to mem_rdata being valid (legal range 1..3).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 fetch, 01 load, 10 store, 11 reserved (treated as load)
- req_addr  in  AW  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_fault  out  2  00 ok, 01 misaligned, 10 protection, 11 range
- resp_data  out  32  fetched instruction or loaded word (0 for a store or a fault)
- instr_reg  out  32  last successfully fetched instruction
- data_reg  out  32  last successfully loaded word
- mem_address  out  AW  to memory address
- mem_writeData  out  32  to memory writeData
- mem_MemWrite  out  1  to memory MemWrite
- mem_rdata  in  32  from memory instruction/data output

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE
  - all outputs 0, except req_ready=1
  - instr_reg, data_reg and the latency counter cleared
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready (accept edge): latch op, addr and wdata, then run the fault check.
  - Fault priority: addr[1:0]!=0 gives 01. Otherwise addr > 2^AW-4 gives 11. Otherwise a store with addr<INSTR_LIMIT, or a fetch with addr>=INSTR_LIMIT, gives 10.
  - Fault: go directly to RESP. No memory activity; mem_MemWrite is never asserted. instr_reg and data_reg are unchanged.
  - No fault: go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_address = latched addr.
  - Store: mem_writeData = wdata unmodified, mem_MemWrite=1 for this cycle only, next state RESP.
  - Read: load the counter with READ_LATENCY, next state WAIT.
- WAIT:
  - mem_address held stable, mem_MemWrite=0, counter decrements each cycle.
  - On the edge where the counter reaches 1, sample mem_rdata and go to RESP.
- Capture rules:
  - Fetch: instr_reg = resp_data = mem_rdata unchanged.
  - Load: the memory returns stored data byte-reversed. Therefore data_reg = resp_data = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]}.
  - Round trip: a store followed by a load of the same address yields the original word.
- RESP:
  - resp_valid=1; resp_data and resp_fault stay stable while resp_ready=0.
  - On resp_ready: go to IDLE; resp_valid, resp_fault and resp_data clear the next cycle.
- Handshake:
  - req_ready=0 in every state except IDLE; one outstanding request at a time.
  - A request presented during RESP is not accepted until the cycle after the response handshake.
- Outside ISSUE/WAIT: mem_address holds its last value; mem_MemWrite=0 and mem_writeData=0 in every state except ISSUE.
- Latency with resp_ready held 1 (edge 0 = accept edge):
  - store: resp_valid during cycle 2
  - read: resp_valid during cycle 2+READ_LATENCY
  - fault: resp_valid during cycle 1
- Reset mid-operation: immediate return to reset values and IDLE; no partial write is retried. A MemWrite pulse cut short by reset is permitted.

Test Plan:
- Reset, then fetch at 0x004 with memory model returning 0x8C010050 -> mem_address=0x004 during ISSUE; resp_valid during cycle 3; resp_data=instr_reg=0x8C010050; resp_fault=00.
- Store 0x11223344 to 0x054, then load 0x054 against a behavioural model of the unified memory -> mem_MemWrite high for exactly 1 cycle; load returns data_reg=0x11223344 (raw mem_rdata 0x44332211).
- Store to 0x028 (instruction region) -> resp_fault=10 at cycle 1; mem_MemWrite never asserted; data_reg unchanged.
- Individual fault cases:
  - load at 0x052 -> 01
  - fetch at 0x050 -> 10
  - load at 0x3FD -> 01
  - load at 0x3FC -> ok
- Hold resp_ready=0 for 5 cycles with req_valid continuously high -> resp_valid and resp_data stable; req_ready=0 throughout; next request accepted the cycle after resp_ready=1. Repeat with READ_LATENCY=3 -> read response at cycle 5.
- Assert rst_n=0 during WAIT of a load -> all outputs zero asynchronously; state IDLE; next fetch completes normally.
